// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a FWFT byte FIFO onto a UART line (start, 8 data LSB first, optional parity, 1-2 stop bits)
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [7:0]  fifo_data,
  input  logic        fifo_empty,
  output logic        fifo_read,
  output logic        tx,
  output logic        busy,
  output logic        tx_done,
  output logic [15:0] frames_sent
);
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
  localparam logic ODD = (PARITY == 2);
  state_t      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [2:0]  bit_q, bit_d;
  logic        stop_q, stop_d;
  logic [7:0]  sh_q, sh_d;
  logic        par_q, par_d;
  logic        tx_q, tx_d;
  logic        armed_q;
  logic [15:0] frames_q;
  logic        last;
  assign last        = timer_q == 16'(CLKS_PER_BIT - 1);
  assign fifo_read   = state_q == IDLE && armed_q && enable && !fifo_empty;
  assign busy        = state_q != IDLE || fifo_read;
  assign tx_done     = state_q == STOP && last && stop_q == 1'(STOP_BITS - 1);
  assign tx          = tx_q;
  assign frames_sent = frames_q;
  // next-state logic: bit timing, shifting, parity accumulation and registered line level
  always_comb begin
    state_d = state_q;
    timer_d = timer_q + 16'd1;
    bit_d   = bit_q;
    stop_d  = stop_q;
    sh_d    = sh_q;
    par_d   = par_q;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (fifo_read) begin
          sh_d    = fifo_data;
          par_d   = 1'b0;
          bit_d   = '0;
          stop_d  = 1'b0;
          state_d = START;
        end
      end
      START: if (last) begin
        timer_d = '0;
        state_d = DATA;
      end
      DATA: if (last) begin
        timer_d = '0;
        sh_d    = sh_q >> 1;
        par_d   = par_q ^ sh_q[0];
        bit_d   = bit_q + 3'd1;
        if (bit_q == 3'd7) state_d = (PARITY != 0) ? PAR : STOP;
      end
      PAR: if (last) begin
        timer_d = '0;
        state_d = STOP;
      end
      STOP: if (last) begin
        timer_d = '0;
        if (stop_q == 1'(STOP_BITS - 1)) state_d = IDLE;
        else stop_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    tx_d = state_d == START ? 1'b0 :
           state_d == DATA  ? sh_d[0] :
           state_d == PAR   ? par_d ^ ODD : 1'b1;
  end
  // state registers; reset drops the frame in flight and forces the line idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      bit_q    <= '0;
      stop_q   <= 1'b0;
      sh_q     <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      armed_q  <= 1'b0;
      frames_q <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      bit_q    <= bit_d;
      stop_q   <= stop_d;
      sh_q     <= sh_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
      armed_q  <= 1'b1;
      if (tx_done) frames_q <= frames_q + 16'd1;
    end
  end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: three configurations checked cycle by cycle against a frame-level UART model
module tb_fifo_uart_tx;
  localparam int N = 3;
  localparam int CPB [N] = '{4, 4, 3};
  localparam int PAR [N] = '{0, 1, 2};
  localparam int STB [N] = '{1, 1, 2};
  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0] enable, fifo_empty, fifo_read, tx, busy, tx_done;
  logic [7:0]  fifo_data [N];
  logic [15:0] frames_sent [N];
  logic [7:0]  mem [N][64];
  int rd [N] = '{default: 0};
  int wr [N] = '{default: 0};
  int exp_frames [N] = '{default: 0};
  int checks = 0;
  int failures = 0;
  bit ok;
  always #5 clk = ~clk;
  for (genvar g = 0; g < N; g++) begin : fm
    assign fifo_empty[g] = rd[g] == wr[g];
    assign fifo_data[g]  = mem[g][rd[g] % 64];
  end
  always @(posedge clk) for (int i = 0; i < N; i++) if (fifo_read[i]) rd[i] <= rd[i] + 1;
  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst_n(rst_n), .enable(enable[0]), .fifo_data(fifo_data[0]), .fifo_empty(fifo_empty[0]),
    .fifo_read(fifo_read[0]), .tx(tx[0]), .busy(busy[0]), .tx_done(tx_done[0]), .frames_sent(frames_sent[0]));
  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1)) u1 (
    .clk(clk), .rst_n(rst_n), .enable(enable[1]), .fifo_data(fifo_data[1]), .fifo_empty(fifo_empty[1]),
    .fifo_read(fifo_read[1]), .tx(tx[1]), .busy(busy[1]), .tx_done(tx_done[1]), .frames_sent(frames_sent[1]));
  fifo_uart_tx #(.CLKS_PER_BIT(3), .PARITY(2), .STOP_BITS(2)) u2 (
    .clk(clk), .rst_n(rst_n), .enable(enable[2]), .fifo_data(fifo_data[2]), .fifo_empty(fifo_empty[2]),
    .fifo_read(fifo_read[2]), .tx(tx[2]), .busy(busy[2]), .tx_done(tx_done[2]), .frames_sent(frames_sent[2]));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic push(input int k, input logic [7:0] b);
    mem[k][wr[k] % 64] = b;
    wr[k]++;
  endtask
  function automatic logic frame_bit(input int k, input logic [7:0] b, input int slot);
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    if (PAR[k] != 0 && slot == 9) return (PAR[k] == 2) ? ~^b : ^b;
    return 1'b1;
  endfunction
  task automatic wait_pop(input int k, input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      found = fifo_read[k];
    end
    chk($sformatf("d%0d_pop_seen", k), 32'(found), 32'd1);
  endtask
  task automatic run_frame(input int k, input int drop_at);
    logic [7:0] b;
    int len;
    logic exp_rd;
    b = mem[k][rd[k] % 64];
    len = CPB[k] * (10 + (PAR[k] != 0 ? 1 : 0) + STB[k] - 1);
    chk($sformatf("d%0d_busy_pop", k), 32'(busy[k]), 32'd1);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (i == drop_at) enable[k] = 1'b0;
      chk($sformatf("d%0d_tx_b%02h_c%0d", k, b, i), 32'(tx[k]), 32'(frame_bit(k, b, i / CPB[k])));
      chk($sformatf("d%0d_busy_c%0d", k, i), 32'(busy[k]), 32'd1);
      chk($sformatf("d%0d_done_c%0d", k, i), 32'(tx_done[k]), 32'(i == len - 1));
      chk($sformatf("d%0d_rd_c%0d", k, i), 32'(fifo_read[k]), 32'd0);
    end
    exp_frames[k]++;
    @(negedge clk);
    exp_rd = enable[k] && rd[k] != wr[k];
    chk($sformatf("d%0d_idle_tx", k), 32'(tx[k]), 32'd1);
    chk($sformatf("d%0d_idle_rd", k), 32'(fifo_read[k]), 32'(exp_rd));
    chk($sformatf("d%0d_idle_busy", k), 32'(busy[k]), 32'(exp_rd));
    chk($sformatf("d%0d_frames", k), 32'(frames_sent[k]), 32'(exp_frames[k]));
  endtask
  task automatic drain(input int k, input int n);
    int pops;
    bit f;
    pops = 0;
    wait_pop(k, 2, f);
    while (f && pops < n + 2) begin
      pops++;
      run_frame(k, -1);
      f = fifo_read[k];
    end
    chk($sformatf("d%0d_pops", k), 32'(pops), 32'(n));
  endtask
  initial begin
    rst_n = 1'b0;
    enable = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("d%0d_rst_tx", k), 32'(tx[k]), 32'd1);
      chk($sformatf("d%0d_rst_rd", k), 32'(fifo_read[k]), 32'd0);
      chk($sformatf("d%0d_rst_busy", k), 32'(busy[k]), 32'd0);
      chk($sformatf("d%0d_rst_done", k), 32'(tx_done[k]), 32'd0);
      chk($sformatf("d%0d_rst_frames", k), 32'(frames_sent[k]), 32'd0);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        chk($sformatf("d%0d_idle_tx_%0d", k, c), 32'(tx[k]), 32'd1);
        chk($sformatf("d%0d_idle_rd_%0d", k, c), 32'(fifo_read[k]), 32'd0);
        chk($sformatf("d%0d_idle_busy_%0d", k, c), 32'(busy[k]), 32'd0);
        chk($sformatf("d%0d_idle_fs_%0d", k, c), 32'(frames_sent[k]), 32'd0);
      end
    end
    for (int k = 0; k < N; k++) begin
      @(posedge clk); #1;
      push(k, 8'hA5);
      drain(k, 1);
      @(posedge clk); #1;
      push(k, 8'h07);
      drain(k, 1);
      @(posedge clk); #1;
      push(k, 8'h01); push(k, 8'h80); push(k, 8'hFF);
      drain(k, 3);
      @(posedge clk); #1;
      repeat (4) push(k, 8'($urandom));
      drain(k, 4);
      enable[k] = 1'b0;
      push(k, 8'($urandom)); push(k, 8'($urandom));
      for (int c = 0; c < 100; c++) begin
        @(negedge clk);
        chk($sformatf("d%0d_gate_rd_%0d", k, c), 32'(fifo_read[k]), 32'd0);
      end
      @(posedge clk); #1;
      enable[k] = 1'b1;
      wait_pop(k, 1, ok);
      if (ok) run_frame(k, 10);
      for (int c = 0; c < 50; c++) begin
        @(negedge clk);
        chk($sformatf("d%0d_drop_rd_%0d", k, c), 32'(fifo_read[k]), 32'd0);
      end
      @(posedge clk); #1;
      enable[k] = 1'b1;
      drain(k, 1);
      @(posedge clk); #1;
      push(k, 8'($urandom)); push(k, 8'($urandom));
      wait_pop(k, 2, ok);
      repeat (4 * CPB[k] + 2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk($sformatf("d%0d_mid_rst_tx", k), 32'(tx[k]), 32'd1);
      chk($sformatf("d%0d_mid_rst_busy", k), 32'(busy[k]), 32'd0);
      chk($sformatf("d%0d_mid_rst_rd", k), 32'(fifo_read[k]), 32'd0);
      chk($sformatf("d%0d_mid_rst_fs", k), 32'(frames_sent[k]), 32'd0);
      exp_frames = '{default: 0};
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      drain(k, 1);
    end
    for (int k = 0; k < N; k++)
      chk($sformatf("d%0d_final_frames", k), 32'(frames_sent[k]), 32'(exp_frames[k]));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
